// File: rtl/stats_pkg.sv
// Shared definitions for the windowed statistics block: register map and delta payload.
package stats_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_D_FLIT   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_D_PKT    = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_D_SOP    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_D_RULE   = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_WIN_CNT  = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_ERR      = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_WINLEN   = 4'd6;

  typedef struct packed {
    logic [DATA_W-1:0] flit;
    logic [DATA_W-1:0] pkt;
    logic [DATA_W-1:0] pkt_sop;
    logic [DATA_W-1:0] rule;
  } stats_regs_t;

endpackage

// File: rtl/stats_window_timer.sv
// Window timer: counts 0..WINDOW_CYCLES-1 while enabled and flags the last cycle of each window.
module stats_window_timer #(
  parameter int unsigned WINDOW_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int unsigned TIMER_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(WINDOW_CYCLES - 1);

  logic [TIMER_W-1:0] timer;

  // clear wins over the window end, so no tick is reported in a clear cycle
  assign tick = en & ~clear & (timer == LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (en) begin
      if (timer == LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/stats_window.sv
// Per-window deltas of four free-running upstream counters, readable through a small register port.
// Optional framing-error detection is built when STATS_WINDOW_ERR_EN is defined.
module stats_window
  import stats_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 250000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] stats_flit,
  input  logic [31:0] stats_pkt,
  input  logic [31:0] stats_pkt_sop,
  input  logic [31:0] stats_rule,
  input  logic        rd_en,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        win_done,
  output logic        err
);

  localparam logic [DATA_W-1:0] WIN_LEN = DATA_W'(WINDOW_CYCLES);

  logic              tick;
  stats_regs_t       cur;
  stats_regs_t       prev;
  stats_regs_t       delta;
  stats_regs_t       next_delta;
  logic [DATA_W-1:0] win_cnt;
  logic [DATA_W-1:0] rd_mux;

  stats_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .en   (en),
    .clear(clear),
    .tick (tick)
  );

  // Modulo-2^32 subtraction absorbs an upstream counter wrap inside the window
  always_comb begin
    cur                = '0;
    cur.flit           = stats_flit;
    cur.pkt            = stats_pkt;
    cur.pkt_sop        = stats_pkt_sop;
    cur.rule           = stats_rule;
    next_delta         = '0;
    next_delta.flit    = cur.flit    - prev.flit;
    next_delta.pkt     = cur.pkt     - prev.pkt;
    next_delta.pkt_sop = cur.pkt_sop - prev.pkt_sop;
    next_delta.rule    = cur.rule    - prev.rule;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prev     <= '0;
      delta    <= '0;
      win_cnt  <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= tick;
      if (clear) begin
        prev    <= cur;
        delta   <= '0;
        win_cnt <= '0;
      end else if (tick) begin
        prev    <= cur;
        delta   <= next_delta;
        win_cnt <= win_cnt + DATA_W'(1);
      end
    end
  end

`ifdef STATS_WINDOW_ERR_EN
  logic [DATA_W-1:0] open_pkts;

  // More than one packet left open, or an eop seen without its sop, within one window
  assign open_pkts = next_delta.pkt_sop - next_delta.pkt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (tick && (open_pkts > DATA_W'(1))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      ADDR_D_FLIT:  rd_mux = delta.flit;
      ADDR_D_PKT:   rd_mux = delta.pkt;
      ADDR_D_SOP:   rd_mux = delta.pkt_sop;
      ADDR_D_RULE:  rd_mux = delta.rule;
      ADDR_WIN_CNT: rd_mux = win_cnt;
      ADDR_ERR:     rd_mux = {31'b0, err};
      ADDR_WINLEN:  rd_mux = WIN_LEN;
      default:      rd_mux = '0;
    endcase
  end

  // Response captures register state before any same-edge tick or clear update
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_stats_window.sv
// Scoreboard bench for stats_window with a 10-cycle window; expectations follow STATS_WINDOW_ERR_EN.
module tb_stats_window;

`ifdef STATS_WINDOW_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        Clk;
  logic        Rst;
  logic        en;
  logic        clear;
  logic [31:0] stats_flit;
  logic [31:0] stats_pkt;
  logic [31:0] stats_pkt_sop;
  logic [31:0] stats_rule;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        win_done;
  logic        err;

  logic [31:0] rd_q[$];
  int unsigned wd_q[$];
  int unsigned cyc;
  int unsigned base;
  logic        exp_err;
  logic        done;
  int unsigned tests;
  int unsigned fails;
  logic [31:0] mon_exp;
  int unsigned mon_cyc;

  stats_window #(
    .WINDOW_CYCLES(10)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .en           (en),
    .clear        (clear),
    .stats_flit   (stats_flit),
    .stats_pkt    (stats_pkt),
    .stats_pkt_sop(stats_pkt_sop),
    .stats_rule   (stats_rule),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .win_done     (win_done),
    .err          (err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  // Inputs change 1 time unit after each rising edge; flit advances every cycle
  task automatic step();
    @(posedge Clk);
    cyc = cyc + 1;
    #1;
    stats_flit = stats_flit + 32'd1;
  endtask

  task automatic go_to(input int unsigned off);
    while (cyc < base + off) step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    rd_q.push_back(e);
    step();
    rd_en   = 1'b0;
    rd_addr = 4'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event is matched against what the stimulus queued
  always @(negedge Clk) begin
    if (Rst) begin
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_rd_valid", {31'b0, rd_data_valid}, 32'd0);
      check("rst_win_done", {31'b0, win_done}, 32'd0);
    end
    if (rd_data_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_valid_spurious", {31'b0, rd_data_valid}, 32'd0);
      end else begin
        mon_exp = rd_q.pop_front();
        check("rd_data", rd_data, mon_exp);
      end
    end
    if (win_done) begin
      if (wd_q.size() == 0) begin
        check("win_done_spurious", {31'b0, win_done}, 32'd0);
      end else begin
        mon_cyc = wd_q.pop_front();
        check("win_done_cycle", 32'(cyc), 32'(mon_cyc));
      end
    end
    check("err", {31'b0, err}, {31'b0, exp_err});
    if (done) begin
      check("rd_q_drained", 32'(rd_q.size()), 32'd0);
      check("wd_q_drained", 32'(wd_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    tests         = 0;
    fails         = 0;
    cyc           = 0;
    base          = 0;
    done          = 1'b0;
    exp_err       = 1'b0;
    Rst           = 1'b0;
    en            = 1'b0;
    clear         = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = 4'd0;
    stats_flit    = 32'd0;
    stats_pkt     = 32'd0;
    stats_pkt_sop = 32'd0;
    stats_rule    = 32'd0;
    #2;
    Rst = 1'b1;
    repeat (3) step();

    // Window 1: counting starts with flit=1 in the first enabled cycle
    Rst           = 1'b0;
    en            = 1'b1;
    stats_flit    = 32'd1;
    stats_pkt     = 32'hFFFF_FFFE;
    stats_pkt_sop = 32'hFFFF_FFFE;
    stats_rule    = 32'd7;
    base          = cyc;
    wd_q.push_back(base + 10);
    wd_q.push_back(base + 20);
    wd_q.push_back(base + 30);
    go_to(2);
    rd(4'd6, 32'd10);
    rd(4'd4, 32'd0);
    rd(4'd5, 32'd0);
    rd(4'd7, 32'd0);
    rd(4'd15, 32'd0);

    // Read in the tick cycle sees the old delta, the next read the new one
    go_to(9);
    rd(4'd0, 32'd0);
    rd(4'd0, 32'd10);
    rd(4'd4, 32'd1);
    rd(4'd1, 32'hFFFF_FFFE);
    rd(4'd2, 32'hFFFF_FFFE);
    rd(4'd3, 32'd7);

    // Window 2: pkt and sop wrap through zero, gaining 5
    stats_pkt     = 32'd3;
    stats_pkt_sop = 32'd3;
    go_to(20);
    rd(4'd1, 32'd5);
    rd(4'd2, 32'd5);
    rd(4'd3, 32'd0);
    rd(4'd4, 32'd2);
    rd(4'd5, 32'd0);

    // Window 3: sop +3, pkt +1 leaves two packets open
    stats_pkt_sop = 32'd6;
    stats_pkt     = 32'd4;
    go_to(30);
    exp_err = ERR_ON;
    rd(4'd5, {31'b0, ERR_ON});
    rd(4'd2, 32'd3);
    rd(4'd1, 32'd1);

    // Window 4: 7 disabled cycles push the window end out by 7
    en = 1'b0;
    wd_q.push_back(base + 47);
    repeat (7) step();
    en = 1'b1;
    go_to(47);
    rd(4'd0, 32'd17);
    rd(4'd4, 32'd4);
    rd(4'd5, {31'b0, ERR_ON});

    // Window 5: clear on the tick cycle; coincident read returns pre-clear data
    go_to(56);
    clear = 1'b1;
    rd(4'd0, 32'd17);
    clear   = 1'b0;
    exp_err = 1'b0;
    wd_q.push_back(base + 67);
    rd(4'd0, 32'd0);
    rd(4'd1, 32'd0);
    rd(4'd4, 32'd0);
    rd(4'd5, 32'd0);
    go_to(67);
    rd(4'd0, 32'd10);
    rd(4'd4, 32'd1);

    // Reset mid-window at timer=5; next delta is measured from zero
    go_to(72);
    Rst     = 1'b1;
    exp_err = 1'b0;
    step();
    step();
    Rst  = 1'b0;
    base = cyc;
    wd_q.push_back(base + 10);
    rd(4'd0, 32'd0);
    rd(4'd4, 32'd0);
    go_to(10);
    exp_err = ERR_ON;
    rd(4'd0, 32'd84);
    rd(4'd1, 32'd4);
    rd(4'd2, 32'd6);
    rd(4'd3, 32'd7);
    rd(4'd4, 32'd1);
    rd(4'd5, {31'b0, ERR_ON});
    step();
    done = 1'b1;
    step();
    step();
  end

endmodule
